// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared widths, arbiter state encodings and default starvation limit
package bram_arbiter_pkg;
   localparam int RAM_ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 32;
   localparam int DEF_STARVE_LIMIT = 4;
   typedef enum logic [1:0] {
      ARB_RUN = 2'd0,
      ARB_DRAIN = 2'd1,
      ARB_LOAD = 2'd2
   } arb_state_t;
endpackage

// File: rtl/bram_arbiter_prio2.sv
// arb_prio2: two-requester priority picker; lo is promoted after LIMIT denied cycles
module arb_prio2
   import bram_arbiter_pkg::*;
#(
   parameter int LIMIT = DEF_STARVE_LIMIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       hi_req,
   input  logic       lo_req,
   output logic [1:0] gnt
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] cnt;
   logic          promote;
   always_comb begin
      promote = cnt == CW'(LIMIT);
      gnt[1] = en && hi_req && !(promote && lo_req);
      gnt[0] = en && lo_req && (promote || !hi_req);
   end
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else cnt <= (!lo_req || gnt[0]) ? '0 : promote ? cnt : cnt + CW'(1);
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: serialises data, fetch and loader accesses onto one BRAM with registered read data
module bram_arbiter
   import bram_arbiter_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_WIDTH,
   parameter int DATA_W = DATA_WIDTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdat,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdat,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdat,
   input  logic              l_lock,
   input  logic              l_req,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdat,
   output logic              l_gnt,
   output logic              lock_ack,
   output logic [ADDR_W-1:0] ram_w_addr,
   output logic [DATA_W-1:0] ram_w_dat,
   output logic              ram_w_enb,
   output logic [3:0]        ram_byte_enb,
   output logic [ADDR_W-1:0] ram_r_addr,
   output logic              ram_r_enb,
   input  logic [DATA_W-1:0] ram_r_dat
);
   arb_state_t state, state_nx;
   logic [1:0] gnt;
   logic       d_rd, d_wr;
   arb_prio2 #(.LIMIT(STARVE_LIMIT)) u_prio (
      .clk,
      .rst,
      .en(state == ARB_RUN),
      .hi_req(d_req),
      .lo_req(f_req),
      .gnt
   );
   always_comb begin
      state_nx = !l_lock ? ARB_RUN : state == ARB_RUN ? ARB_DRAIN : ARB_LOAD;
      d_gnt = gnt[1];
      f_gnt = gnt[0];
      d_rd = d_gnt && !d_we;
      d_wr = d_gnt && d_we;
      lock_ack = state == ARB_LOAD && l_lock;
      l_gnt = lock_ack && l_req;
      ram_w_enb = d_wr || l_gnt;
      ram_r_enb = d_rd || f_gnt;
      ram_w_addr = l_gnt ? l_addr : d_wr ? d_addr : '0;
      ram_w_dat = l_gnt ? l_wdat : d_wr ? d_wdat : '0;
      ram_byte_enb = l_gnt ? 4'b1111 : d_wr ? d_be : 4'b0000;
      ram_r_addr = f_gnt ? f_addr : d_rd ? d_addr : '0;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= ARB_RUN;
         d_rvalid <= 1'b0;
         f_rvalid <= 1'b0;
         d_rdat <= '0;
         f_rdat <= '0;
      end else begin
         state <= state_nx;
         d_rvalid <= d_rd;
         f_rvalid <= f_gnt;
         if (d_rd) d_rdat <= ram_r_dat;
         if (f_gnt) f_rdat <= ram_r_dat;
      end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed and random scoreboard bench for bram_arbiter with a behavioural BRAM
module tb_bram_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   logic clk = 1'b0, rst = 1'b1, preload = 1'b1, auto_push = 1'b0;
   logic d_req = 0, d_we = 0, f_req = 0, l_lock = 0, l_req = 0;
   logic [AW-1:0] d_addr = '0, f_addr = '0, l_addr = '0;
   logic [DW-1:0] d_wdat = '0, l_wdat = '0;
   logic [3:0] d_be = '0;
   logic d_gnt, d_rvalid, f_gnt, f_rvalid, l_gnt, lock_ack, ram_w_enb, ram_r_enb;
   logic [DW-1:0] d_rdat, f_rdat, ram_w_dat, ram_r_dat;
   logic [AW-1:0] ram_w_addr, ram_r_addr;
   logic [3:0] ram_byte_enb;
   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] dq[$], fq[$];
   int checks = 0, errors = 0, excl_viol = 0, grant_viol = 0, acc_rd = 0, rv = 0;
   always #5 clk = ~clk;
   bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk, .rst, .d_req, .d_we, .d_addr, .d_wdat, .d_be, .d_gnt, .d_rvalid, .d_rdat,
      .f_req, .f_addr, .f_gnt, .f_rvalid, .f_rdat, .l_lock, .l_req, .l_addr, .l_wdat,
      .l_gnt, .lock_ack, .ram_w_addr, .ram_w_dat, .ram_w_enb, .ram_byte_enb,
      .ram_r_addr, .ram_r_enb, .ram_r_dat
   );
   function automatic logic [DW-1:0] init_word(input int i);
      return i == 3 ? 32'hDEADBEEF : i == 1 ? 32'h00500093 : i == 4 ? 32'h0 : 32'h5A000000 | i;
   endfunction
   assign ram_r_dat = mem[ram_r_addr[AW-1:2]];
   always @(posedge clk)
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      end else if (ram_w_enb) begin
         for (int b = 0; b < 4; b++)
            if (ram_byte_enb[b]) mem[ram_w_addr[AW-1:2]][8*b+:8] <= ram_w_dat[8*b+:8];
      end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge clk) begin
      if (d_rvalid) begin
         if (dq.size() == 0) chk("d_rvalid_spurious", 1, 0);
         else chk("d_rdat", d_rdat, dq.pop_front());
      end
      if (f_rvalid) begin
         if (fq.size() == 0) chk("f_rvalid_spurious", 1, 0);
         else chk("f_rdat", f_rdat, fq.pop_front());
      end
      if (ram_w_enb && ram_r_enb) excl_viol++;
      if (32'(d_gnt) + 32'(f_gnt) + 32'(l_gnt) > 1) grant_viol++;
      if ((d_gnt && !d_we) || f_gnt) acc_rd++;
      rv += 32'(d_rvalid) + 32'(f_rvalid);
      if (auto_push && d_gnt && !d_we) dq.push_back(mem[d_addr[AW-1:2]]);
      if (auto_push && f_gnt) fq.push_back(mem[f_addr[AW-1:2]]);
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic d_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w,
                       input logic [3:0] be, input logic [DW-1:0] exp);
      int n = 0;
      d_req = 1; d_we = we; d_addr = a; d_wdat = w; d_be = be;
      if (!we) dq.push_back(exp);
      #1;
      while (!d_gnt && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("d_gnt_wait", d_gnt, 1);
      cyc();
      d_req = 0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1);
   end
   initial begin
      int n, acc0, rv0;
      logic dg, fg;
      repeat (2) @(posedge clk);
      #1;
      rst = 0; preload = 0;
      #1;
      chk("reset_outs", {d_gnt, d_rvalid, f_gnt, f_rvalid, l_gnt, lock_ack, ram_w_enb, ram_r_enb,
                         ram_byte_enb, ram_r_addr, ram_w_addr}, 0);
      chk("reset_rdat", {d_rdat, f_rdat}, 0);
      cyc();
      // single load
      d_req = 1; d_we = 0; d_addr = 12'h00C;
      dq.push_back(32'hDEADBEEF);
      #1;
      chk("load_gnt", {d_gnt, ram_r_enb, ram_w_enb}, 3'b110);
      chk("load_raddr", ram_r_addr, 12'h00C);
      cyc();
      d_req = 0;
      #1;
      chk("load_rvalid", {d_rvalid, ram_w_enb}, 2'b10);
      chk("load_rdat", d_rdat, 32'hDEADBEEF);
      cyc();
      #1;
      chk("load_rvalid_one", d_rvalid, 0);
      chk("load_rdat_hold", d_rdat, 32'hDEADBEEF);
      // byte stores then read back
      d_req = 1; d_we = 1; d_addr = 12'h010; d_wdat = 32'h000000AB; d_be = 4'b0001;
      #1;
      chk("store_gnt", {d_gnt, ram_w_enb, ram_r_enb}, 3'b110);
      chk("store_be", ram_byte_enb, 4'b0001);
      chk("store_wa", {ram_w_addr, ram_w_dat}, {12'h010, 32'h000000AB});
      cyc();
      d_req = 0;
      #1;
      chk("store_no_rvalid", d_rvalid, 0);
      cyc();
      d_op(1, 12'h010, 32'h11223344, 4'b1100, 0);
      d_op(0, 12'h010, 0, 0, 32'h112200AB);
      cyc();
      // contention: four data grants, then promoted fetch
      d_req = 1; d_we = 0; d_addr = 12'h00C; f_req = 1; f_addr = 12'h004;
      for (int k = 1; k <= 6; k++) begin
         #1;
         chk($sformatf("cont_gnt_%0d", k), {d_gnt, f_gnt}, k == 5 ? 2'b01 : 2'b10);
         if (k == 5) fq.push_back(32'h00500093);
         else dq.push_back(32'hDEADBEEF);
         cyc();
      end
      d_req = 0; f_req = 0;
      cyc();
      cyc();
      // loader: pending fetch drains, then exclusive word write
      l_lock = 1; l_req = 1; l_addr = 12'h000; l_wdat = 32'h00000013; f_req = 1; f_addr = 12'h004;
      fq.push_back(32'h00500093);
      #1;
      chk("lock_fetch_gnt", {f_gnt, l_gnt, lock_ack}, 3'b100);
      cyc();
      f_req = 0;
      n = 0;
      #1;
      while (!lock_ack && n < 2) begin
         chk("l_gnt_outside_load", l_gnt, 0);
         cyc();
         #1;
         n++;
      end
      chk("lock_ack_in2", lock_ack, 1);
      f_req = 1; f_addr = 12'h000; d_req = 1; d_we = 0; d_addr = 12'h00C;
      #1;
      chk("load_write", {l_gnt, f_gnt, d_gnt, ram_w_enb, ram_r_enb}, 5'b10010);
      chk("load_wfields", {ram_byte_enb, ram_w_addr, ram_w_dat}, {4'b1111, 12'h000, 32'h00000013});
      cyc();
      l_req = 0; d_req = 0; l_lock = 0;
      #1;
      chk("unlock_ack_drop", {lock_ack, f_gnt}, 2'b00);
      fq.push_back(32'h00000013);
      cyc();
      #1;
      chk("post_load_fetch", f_gnt, 1);
      cyc();
      f_req = 0;
      cyc();
      // reset at the accepting edge drops the read
      d_req = 1; d_we = 0; d_addr = 12'h00C; rst = 1;
      #1;
      chk("rst_gnt", d_gnt, 1);
      cyc();
      d_req = 0; rst = 0;
      #1;
      chk("rst_outs", {d_gnt, d_rvalid, f_gnt, f_rvalid, l_gnt, lock_ack, ram_w_enb, ram_r_enb,
                       ram_byte_enb, ram_r_addr, ram_w_addr}, 0);
      chk("rst_rdat", {d_rdat, f_rdat}, 0);
      cyc();
      d_op(0, 12'h004, 0, 0, 32'h00500093);
      repeat (3) cyc();
      // random read traffic
      acc0 = acc_rd; rv0 = rv; auto_push = 1;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         dg = d_gnt; fg = f_gnt;
         cyc();
         if (!d_req || dg) begin
            d_req = 1'($urandom_range(0, 1));
            d_addr = AW'($urandom_range(0, 1023) << 2);
         end
         if (!f_req || fg) begin
            f_req = 1'($urandom_range(0, 1));
            f_addr = AW'($urandom_range(0, 1023) << 2);
         end
      end
      @(negedge clk);
      cyc();
      d_req = 0; f_req = 0;
      repeat (3) cyc();
      auto_push = 0;
      chk("rvalid_per_read", rv - rv0, acc_rd - acc0);
      chk("exclusive_rw", excl_viol, 0);
      chk("one_grant", grant_viol, 0);
      chk("queues_empty", dq.size() + fq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
